// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze/timeout sequencer: qualifies comparator matches by day,
// drives the buzzer and tracks snooze usage and missed alarms.
module alarm_sequencer #(
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned RING_MIN   = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       min_tick,
  input  logic       aa,
  input  logic [2:0] cd,
  input  logic [6:0] day_en,
  input  logic       snooze_btn,
  input  logic       off_btn,
  output logic       buzzer,
  output logic       snoozing,
  output logic [3:0] snooze_left,
  output logic [2:0] snooze_used,
  output logic       missed
);

  // state  | meaning
  // IDLE   | waiting for an enabled alarm match
  // RING   | buzzer on, counting unattended minutes
  // SNOOZE | buzzer off, counting down the snooze period
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam logic [3:0] SNOOZE_LEN = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LAST  = 4'(RING_MIN - 1);
  localparam logic [2:0] SNOOZE_MAX = 3'(MAX_SNOOZE);

  state_t     state, state_nx;
  logic       aa_q, sn_q, off_q;
  logic [3:0] ring_cnt, ring_cnt_nx;
  logic [3:0] snooze_left_nx;
  logic [2:0] snooze_used_nx;
  logic       missed_nx;
  logic       aa_rise, sn_p, off_p, trig;
  logic [7:0] day_en_x;

  // Day 7 maps onto a constant-zero enable bit, so it can never trigger.
  assign day_en_x = {1'b0, day_en};
  assign aa_rise  = aa & ~aa_q;
  assign sn_p     = snooze_btn & ~sn_q;
  assign off_p    = off_btn & ~off_q;
  assign trig     = aa_rise & day_en_x[cd];

  always_comb begin
    state_nx       = state;
    ring_cnt_nx    = ring_cnt;
    snooze_left_nx = snooze_left;
    snooze_used_nx = snooze_used;
    missed_nx      = missed;
    unique case (state)
      IDLE: begin
        if (trig) begin
          state_nx       = RING;
          ring_cnt_nx    = '0;
          snooze_used_nx = '0;
          missed_nx      = 1'b0;
        end else if (off_p) begin
          missed_nx = 1'b0;
        end
      end
      RING: begin
        if (off_p) begin
          state_nx = IDLE;
        end else if (sn_p && (snooze_used < SNOOZE_MAX)) begin
          state_nx       = SNOOZE;
          snooze_left_nx = SNOOZE_LEN;
          snooze_used_nx = snooze_used + 3'd1;
        end else if (min_tick && (ring_cnt == RING_LAST)) begin
          state_nx  = IDLE;
          missed_nx = 1'b1;
        end else if (min_tick && (ring_cnt != 4'hF)) begin
          ring_cnt_nx = ring_cnt + 4'd1;
        end
      end
      SNOOZE: begin
        if (off_p) begin
          state_nx       = IDLE;
          snooze_left_nx = '0;
        end else if (min_tick && (snooze_left == 4'd1)) begin
          state_nx       = RING;
          ring_cnt_nx    = '0;
          snooze_left_nx = '0;
        end else if (min_tick && (snooze_left != 4'd0)) begin
          snooze_left_nx = snooze_left - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      aa_q        <= 1'b0;
      sn_q        <= 1'b0;
      off_q       <= 1'b0;
      ring_cnt    <= '0;
      snooze_left <= '0;
      snooze_used <= '0;
      missed      <= 1'b0;
      buzzer      <= 1'b0;
      snoozing    <= 1'b0;
    end else begin
      state       <= state_nx;
      aa_q        <= aa;
      sn_q        <= snooze_btn;
      off_q       <= off_btn;
      ring_cnt    <= ring_cnt_nx;
      snooze_left <= snooze_left_nx;
      snooze_used <= snooze_used_nx;
      missed      <= missed_nx;
      buzzer      <= (state_nx == RING);
      snoozing    <= (state_nx == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: trigger, day mask, snooze, limit,
// timeout, event priority and asynchronous reset mid-event.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       min_tick = 1'b0;
  logic       aa = 1'b0;
  logic [2:0] cd = 3'd0;
  logic [6:0] day_en = 7'h00;
  logic       snooze_btn = 1'b0;
  logic       off_btn = 1'b0;
  logic       buzzer, snoozing, missed;
  logic [3:0] snooze_left;
  logic [2:0] snooze_used;

  int n_pass = 0;
  int n_total = 0;

  alarm_sequencer #(.SNOOZE_MIN(9), .RING_MIN(5), .MAX_SNOOZE(3)) dut (
    .clk(clk), .rst_n(rst_n), .min_tick(min_tick), .aa(aa), .cd(cd),
    .day_en(day_en), .snooze_btn(snooze_btn), .off_btn(off_btn),
    .buzzer(buzzer), .snoozing(snoozing), .snooze_left(snooze_left),
    .snooze_used(snooze_used), .missed(missed)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_min();
    min_tick = 1'b1;
    step();
    min_tick = 1'b0;
    step();
  endtask

  task automatic trigger();
    aa = 1'b1;
    step();
    aa = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_buzzer"}, 32'(buzzer), 32'd0);
    check_val({tag, "_snoozing"}, 32'(snoozing), 32'd0);
    check_val({tag, "_snooze_left"}, 32'(snooze_left), 32'd0);
    check_val({tag, "_snooze_used"}, 32'(snooze_used), 32'd0);
    check_val({tag, "_missed"}, 32'(missed), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    logic prev;

    #3;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    // trigger and off
    day_en = 7'h7F;
    cd = 3'd2;
    trigger();
    check_val("trig_buzzer", 32'(buzzer), 32'd1);
    check_val("trig_used", 32'(snooze_used), 32'd0);
    off_btn = 1'b1;
    step();
    check_val("off_buzzer", 32'(buzzer), 32'd0);
    check_val("off_missed", 32'(missed), 32'd0);
    off_btn = 1'b0;
    step();

    // disabled day, then a held match on an enabled day
    day_en = 7'b1111011;
    trigger();
    step();
    check_val("dis_day_buzzer", 32'(buzzer), 32'd0);
    cd = 3'd3;
    aa = 1'b1;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      off_btn = (i == 50);
      step();
      if (buzzer && !prev) rises++;
      prev = buzzer;
    end
    check_val("held_aa_rises", 32'(rises), 32'd1);
    check_val("held_aa_buzzer", 32'(buzzer), 32'd0);
    aa = 1'b0;
    off_btn = 1'b0;
    step();

    // snooze period; button held several cycles counts once
    trigger();
    check_val("snz_ring", 32'(buzzer), 32'd1);
    snooze_btn = 1'b1;
    step();
    check_val("snz_snoozing", 32'(snoozing), 32'd1);
    check_val("snz_left", 32'(snooze_left), 32'd9);
    check_val("snz_used", 32'(snooze_used), 32'd1);
    check_val("snz_buzzer", 32'(buzzer), 32'd0);
    repeat (3) step();
    snooze_btn = 1'b0;
    step();
    for (int i = 0; i < 8; i++) tick_min();
    check_val("snz_left_1", 32'(snooze_left), 32'd1);
    check_val("snz_still_quiet", 32'(buzzer), 32'd0);
    min_tick = 1'b1;
    step();
    min_tick = 1'b0;
    check_val("snz_end_buzzer", 32'(buzzer), 32'd1);
    check_val("snz_end_snoozing", 32'(snoozing), 32'd0);
    check_val("snz_end_left", 32'(snooze_left), 32'd0);
    step();

    // snoozes 2 and 3, then the 4th is refused
    for (int s = 2; s <= 3; s++) begin
      snooze_btn = 1'b1;
      step();
      snooze_btn = 1'b0;
      check_val("lim_used", 32'(snooze_used), 32'(s));
      step();
      for (int i = 0; i < 9; i++) tick_min();
      check_val("lim_back_ring", 32'(buzzer), 32'd1);
    end
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    check_val("lim4_buzzer", 32'(buzzer), 32'd1);
    check_val("lim4_snoozing", 32'(snoozing), 32'd0);
    check_val("lim4_used", 32'(snooze_used), 32'd3);
    step();
    for (int i = 0; i < 4; i++) tick_min();
    check_val("to_pre_buzzer", 32'(buzzer), 32'd1);
    min_tick = 1'b1;
    step();
    min_tick = 1'b0;
    check_val("to_buzzer", 32'(buzzer), 32'd0);
    check_val("to_missed", 32'(missed), 32'd1);
    step();
    off_btn = 1'b1;
    step();
    off_btn = 1'b0;
    check_val("idle_off_missed", 32'(missed), 32'd0);
    step();

    // coinciding events
    trigger();
    off_btn = 1'b1;
    snooze_btn = 1'b1;
    step();
    off_btn = 1'b0;
    snooze_btn = 1'b0;
    check_val("both_buzzer", 32'(buzzer), 32'd0);
    check_val("both_snoozing", 32'(snoozing), 32'd0);
    check_val("both_used", 32'(snooze_used), 32'd0);
    step();
    trigger();
    for (int i = 0; i < 4; i++) tick_min();
    min_tick = 1'b1;
    off_btn = 1'b1;
    step();
    min_tick = 1'b0;
    off_btn = 1'b0;
    check_val("off_vs_to_buzzer", 32'(buzzer), 32'd0);
    check_val("off_vs_to_missed", 32'(missed), 32'd0);
    step();

    // asynchronous reset mid-snooze
    trigger();
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
    step();
    for (int i = 0; i < 4; i++) tick_min();
    check_val("pre_rst_left", 32'(snooze_left), 32'd5);
    aa = 1'b1;
    rst_n = 1'b0;
    #2;
    check_zero("async_rst");
    @(negedge clk) rst_n = 1'b1;
    step();
    check_val("post_rst_trig", 32'(buzzer), 32'd1);
    aa = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
